// File: rtl/peak_topk_if.sv
// Peak-in / AXI-stream-out bundle for peak_topk.
// Latency: none (wires only).
// Backpressure: m_tready on the stream side; the peak side has no ready.
interface peak_topk_if;
    logic        p_valid;
    logic        p_last;
    logic [31:0] p_i_s;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;

    // Peak source and stream sink (the environment around the collector)
    modport master (
        output p_valid, p_last, p_i_s, m_tready,
        input  m_tvalid, m_tdata, m_tlast
    );

    // The collector itself
    modport slave (
        input  p_valid, p_last, p_i_s, m_tready,
        output m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/constants.vh
// Shared field widths for the peak word: value occupies the top VALUE_WIDTH bits,
// one side bit follows, and the index occupies the bottom INDEX_WIDTH bits.
// The remaining bits are carried through untouched.
`ifndef PEAK_TOPK_CONSTANTS_VH
`define PEAK_TOPK_CONSTANTS_VH
`define VALUE_WIDTH 16
`define INDEX_WIDTH 8
`endif

// File: rtl/peak_topk.sv
// Keeps the K largest peaks of each frame (by unsigned value, ties keep arrival order) and streams them largest-first.
// Latency: single-cycle insertion; first result beat is valid the cycle after the frame-closing p_last.
// Backpressure: input never stalls; a frame closing while the previous result still drains is dropped and sets overflow.
// Optional macro PEAK_TOPK_STATS_EN adds saturating peaks_seen / peaks_dropped counters.
`include "constants.vh"

module peak_topk #(
    parameter int K = 4
) (
    input  logic       clk,
    input  logic       aresetn,
    peak_topk_if.slave bus,
    output logic       overflow,
    output logic       empty_frame
`ifdef PEAK_TOPK_STATS_EN
    ,
    output logic [15:0] peaks_seen,
    output logic [15:0] peaks_dropped
`endif
);
    localparam int VW = `VALUE_WIDTH;
    localparam int CW = $clog2(K + 1);
    localparam int RW = $clog2(K);
    localparam logic [CW-1:0] FULL    = CW'(K);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [RW-1:0] RD_ONE  = RW'(1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [1:0]    rst_sync;
    logic          rst_n;
    logic [31:0]   col     [K];
    logic [31:0]   col_ins [K];
    logic [31:0]   bank    [K];
    logic [CW-1:0] col_cnt, ins_cnt, bank_cnt;
    logic [RW-1:0] rd;
    logic [K-1:0]  ge;
    logic          full, ins_drop, ins_evict;
    logic          beat_hs, tlast_hs, close_nonempty, load, discard;

    // Reset asserts immediately but releases two edges later, so no flop sees a partial first edge
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Parallel compare-and-shift: entries >= the new value stay, the first smaller slot takes the new word
    always_comb begin
        for (int i = 0; i < K; i++)
            ge[i] = (i < int'(col_cnt)) && (col[i][31 -: VW] >= bus.p_i_s[31 -: VW]);
        col_ins[0] = (!bus.p_valid || ge[0]) ? col[0] : bus.p_i_s;
        for (int i = 1; i < K; i++)
            col_ins[i] = (!bus.p_valid || ge[i]) ? col[i] : (ge[i-1] ? bus.p_i_s : col[i-1]);
        full      = (col_cnt == FULL);
        ins_drop  = bus.p_valid && full && ge[K-1];
        ins_evict = bus.p_valid && full && !ge[K-1];
        ins_cnt   = (bus.p_valid && !full) ? col_cnt + CNT_ONE : col_cnt;
    end

    // Frame-close decision: a bank can be loaded when idle or when the last beat leaves this very edge
    always_comb begin
        beat_hs        = bus.m_tvalid && bus.m_tready;
        tlast_hs       = beat_hs && bus.m_tlast;
        close_nonempty = bus.p_last && (ins_cnt != '0);
        load           = close_nonempty && ((state == IDLE) || tlast_hs);
        discard        = close_nonempty && !load;
    end

    // Drain FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Drain FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = DRAIN;
            DRAIN:   if (tlast_hs && !load) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stream outputs come straight from the bank, so they hold while the sink stalls
    always_comb begin
        bus.m_tvalid = (state == DRAIN);
        bus.m_tdata  = '0;
        bus.m_tlast  = 1'b0;
        if (state == DRAIN) begin
            bus.m_tdata = bank[rd];
            bus.m_tlast = (int'(rd) == int'(bank_cnt) - 1);
        end
    end

    // Collect array: insert on each peak, clear whenever a frame closes (kept, discarded or empty)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) col[i] <= '0;
            col_cnt <= '0;
        end else if (bus.p_last) begin
            for (int i = 0; i < K; i++) col[i] <= '0;
            col_cnt <= '0;
        end else if (bus.p_valid) begin
            for (int i = 0; i < K; i++) col[i] <= col_ins[i];
            col_cnt <= ins_cnt;
        end
    end

    // Output bank, read pointer and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) bank[i] <= '0;
            bank_cnt    <= '0;
            rd          <= '0;
            overflow    <= 1'b0;
            empty_frame <= 1'b0;
        end else begin
            empty_frame <= bus.p_last && (ins_cnt == '0);
            if (discard) overflow <= 1'b1;
            if (load) begin
                for (int i = 0; i < K; i++) bank[i] <= col_ins[i];
                bank_cnt <= ins_cnt;
                rd       <= '0;
            end else if (tlast_hs) begin
                rd <= '0;
            end else if (beat_hs) begin
                rd <= rd + RD_ONE;
            end
        end
    end

`ifdef PEAK_TOPK_STATS_EN
    logic [16:0] seen_sum, drop_sum;

    // Saturating sums: a discarded frame counts all the peaks it held
    always_comb begin
        seen_sum = {1'b0, peaks_seen} + 17'(bus.p_valid);
        drop_sum = {1'b0, peaks_dropped} + 17'(ins_drop || ins_evict)
                 + (discard ? 17'(ins_cnt) : 17'd0);
    end

    // Statistics counters, cleared by reset only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peaks_seen    <= '0;
            peaks_dropped <= '0;
        end else begin
            peaks_seen    <= seen_sum[16] ? 16'hFFFF : seen_sum[15:0];
            peaks_dropped <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`else
    // Drop/evict indications only feed the optional statistics
    logic unused_stats;
    assign unused_stats = ins_drop ^ ins_evict;
`endif

endmodule

// File: tb/tb_peak_topk.sv
// Directed bench for peak_topk (K=4, 16-bit value field, 8-bit index field).
// Per-cycle vector table drives inputs on the falling edge and checks outputs one cycle later.
// Hand-written sequences cover reset state and asynchronous reset during a drain.
module tb_peak_topk;
    logic clk = 1'b0;
    logic aresetn = 1'b0;
    logic overflow, empty_frame;
    int   checks = 0;
    int   errors = 0;

    peak_topk_if bus();

    peak_topk #(.K(4)) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .bus        (bus),
        .overflow   (overflow),
        .empty_frame(empty_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv, pl, rdy;
        logic [15:0] val;
        logic [8:0]  si;      // {side, index}
        logic        e_vld;
        logic [15:0] e_val;
        logic [8:0]  e_si;
        logic        e_last, e_ovf, e_emp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] w(input logic [15:0] val, input logic [8:0] si);
        return {val, si[8], 7'b0, si[7:0]};
    endfunction

    task automatic v(input logic pv, input logic pl, input logic rdy,
                     input logic [15:0] val, input logic [8:0] si,
                     input logic e_vld, input logic [15:0] e_val, input logic [8:0] e_si,
                     input logic e_last, input logic e_ovf, input logic e_emp);
        vec_t r;
        r.pv = pv; r.pl = pl; r.rdy = rdy; r.val = val; r.si = si;
        r.e_vld = e_vld; r.e_val = e_val; r.e_si = e_si;
        r.e_last = e_last; r.e_ovf = e_ovf; r.e_emp = e_emp;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, n, act, exp);
        end
    endtask

    initial begin
        bus.p_valid  = 1'b0;
        bus.p_last   = 1'b0;
        bus.p_i_s    = '0;
        bus.m_tready = 1'b0;

        // Reset state
        #12;
        chk("rst_tvalid", 0, 32'(bus.m_tvalid), 0);
        chk("rst_tlast",  0, 32'(bus.m_tlast), 0);
        chk("rst_tdata",  0, bus.m_tdata, 0);
        chk("rst_ovf",    0, 32'(overflow), 0);
        chk("rst_empty",  0, 32'(empty_frame), 0);
        @(negedge clk);
        aresetn = 1'b1;
        repeat (3) @(negedge clk);

        // Six peaks, separate p_last: top four out, largest first
        v(1,0,1,16'h0004,9'h000, 0,0,0,0,0,0);
        v(1,0,1,16'h0028,9'h001, 0,0,0,0,0,0);
        v(1,0,1,16'h0A34,9'h002, 0,0,0,0,0,0);
        v(1,0,1,16'h0514,9'h003, 0,0,0,0,0,0);
        v(1,0,1,16'h00C3,9'h004, 0,0,0,0,0,0);
        v(1,0,1,16'h0037,9'h005, 0,0,0,0,0,0);
        v(0,1,1,16'h0000,9'h000, 1,16'h0A34,9'h002,0,0,0);
        v(0,0,1,16'h0000,9'h000, 1,16'h0514,9'h003,0,0,0);
        v(0,0,1,16'h0000,9'h000, 1,16'h00C3,9'h004,0,0,0);
        v(0,0,1,16'h0000,9'h000, 1,16'h0037,9'h005,1,0,0);
        v(0,0,1,16'h0000,9'h000, 0,0,0,0,0,0);
        // Ties keep arrival order; last peak arrives with p_last
        v(1,0,1,16'h00C3,9'h001, 0,0,0,0,0,0);
        v(1,0,1,16'h00C3,9'h002, 0,0,0,0,0,0);
        v(1,1,1,16'h00C1,9'h003, 1,16'h00C3,9'h001,0,0,0);
        v(0,0,1,16'h0000,9'h000, 1,16'h00C3,9'h002,0,0,0);
        v(0,0,1,16'h0000,9'h000, 1,16'h00C1,9'h003,1,0,0);
        v(0,0,1,16'h0000,9'h000, 0,0,0,0,0,0);
        // Empty frame
        v(0,1,1,16'h0000,9'h000, 0,0,0,0,0,1);
        v(0,0,1,16'h0000,9'h000, 0,0,0,0,0,0);
        // Next frame closes on the same edge as the previous frame's last handshake
        v(1,0,1,16'h0100,9'h001, 0,0,0,0,0,0);
        v(1,1,1,16'h0050,9'h002, 1,16'h0100,9'h001,0,0,0);
        v(1,0,1,16'h0077,9'h003, 1,16'h0050,9'h002,1,0,0);
        v(0,1,1,16'h0000,9'h000, 1,16'h0077,9'h003,1,0,0);
        v(0,0,1,16'h0000,9'h000, 0,0,0,0,0,0);
        // Full array: equal-to-smallest dropped, tie at top ranks below, smaller dropped, side bit ignored
        v(1,0,1,16'h0010,9'h000, 0,0,0,0,0,0);
        v(1,0,1,16'h0020,9'h101, 0,0,0,0,0,0);
        v(1,0,1,16'h0030,9'h002, 0,0,0,0,0,0);
        v(1,0,1,16'h0040,9'h003, 0,0,0,0,0,0);
        v(1,0,1,16'h0010,9'h004, 0,0,0,0,0,0);
        v(1,0,1,16'h0040,9'h005, 0,0,0,0,0,0);
        v(1,1,1,16'h0015,9'h006, 1,16'h0040,9'h003,0,0,0);
        v(0,0,1,16'h0000,9'h000, 1,16'h0040,9'h005,0,0,0);
        v(0,0,1,16'h0000,9'h000, 1,16'h0030,9'h002,0,0,0);
        v(0,0,1,16'h0000,9'h000, 1,16'h0020,9'h101,1,0,0);
        v(0,0,1,16'h0000,9'h000, 0,0,0,0,0,0);
        // Stalled drain, second frame closes before tlast: overflow, first intact, second lost
        v(1,0,0,16'h0300,9'h001, 0,0,0,0,0,0);
        v(1,1,0,16'h0200,9'h002, 1,16'h0300,9'h001,0,0,0);
        v(1,0,0,16'h0999,9'h003, 1,16'h0300,9'h001,0,0,0);
        v(0,1,0,16'h0000,9'h000, 1,16'h0300,9'h001,0,1,0);
        v(0,0,1,16'h0000,9'h000, 1,16'h0200,9'h002,1,1,0);
        v(0,0,1,16'h0000,9'h000, 0,0,0,0,1,0);
        v(0,0,1,16'h0000,9'h000, 0,0,0,0,1,0);

        @(negedge clk);
        foreach (tbl[i]) begin
            bus.p_valid  = tbl[i].pv;
            bus.p_last   = tbl[i].pl;
            bus.m_tready = tbl[i].rdy;
            bus.p_i_s    = tbl[i].pv ? w(tbl[i].val, tbl[i].si) : 32'h0;
            @(negedge clk);
            chk("tvalid", i, 32'(bus.m_tvalid), 32'(tbl[i].e_vld));
            chk("tdata",  i, bus.m_tdata, tbl[i].e_vld ? w(tbl[i].e_val, tbl[i].e_si) : 32'h0);
            chk("tlast",  i, 32'(bus.m_tlast), 32'(tbl[i].e_last));
            chk("overflow", i, 32'(overflow), 32'(tbl[i].e_ovf));
            chk("empty_frame", i, 32'(empty_frame), 32'(tbl[i].e_emp));
        end

        // Asynchronous reset mid-drain with a partial frame in collection
        bus.p_valid = 1'b1; bus.p_last = 1'b0; bus.m_tready = 1'b0; bus.p_i_s = w(16'h0500, 9'h001);
        @(negedge clk);
        bus.p_last = 1'b1; bus.p_i_s = w(16'h0600, 9'h002);
        @(negedge clk);
        bus.p_last = 1'b0; bus.p_i_s = w(16'hFFFF, 9'h009);
        @(negedge clk);
        chk("pre_rst_tdata", 100, bus.m_tdata, w(16'h0600, 9'h002));
        bus.p_valid = 1'b0; bus.p_i_s = '0;
        #2 aresetn = 1'b0;
        #1;
        chk("arst_tvalid", 101, 32'(bus.m_tvalid), 0);
        chk("arst_tdata",  101, bus.m_tdata, 0);
        chk("arst_ovf",    101, 32'(overflow), 0);
        @(negedge clk);
        aresetn = 1'b1;
        repeat (3) @(negedge clk);
        bus.p_valid = 1'b1; bus.p_last = 1'b1; bus.m_tready = 1'b1; bus.p_i_s = w(16'h2837, 9'h004);
        @(negedge clk);
        bus.p_valid = 1'b0; bus.p_last = 1'b0; bus.p_i_s = '0;
        chk("post_rst_tvalid", 102, 32'(bus.m_tvalid), 1);
        chk("post_rst_tdata",  102, bus.m_tdata, w(16'h2837, 9'h004));
        chk("post_rst_tlast",  102, 32'(bus.m_tlast), 1);
        @(negedge clk);
        chk("post_rst_done",   103, 32'(bus.m_tvalid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/peak_topk.md
PEAK_TOPK -- requirements
Module: peak_topk

Interface
REQ-001 SHALL have parameter K, default 4, meaning number of largest peaks retained per frame (2..16).
REQ-002 SHALL take VALUE_WIDTH and INDEX_WIDTH from constants.vh; no local override.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 aresetn  input  1  asynchronous, active-low reset.
REQ-005 p_valid  input  1  p_i_s carries a peak this cycle.
REQ-006 p_last  input  1  frame end (peak detector last_out); may assert with or without p_valid.
REQ-007 p_i_s  input  32  peak word: value = [31:32-VALUE_WIDTH], side = [31-VALUE_WIDTH], index = [INDEX_WIDTH-1:0].
REQ-008 m_tvalid  output  1  AXI-stream valid.
REQ-009 m_tready  input  1  AXI-stream ready.
REQ-010 m_tdata  output  32  retained peak word, unmodified p_i_s format.
REQ-011 m_tlast  output  1  final beat of a frame's result.
REQ-012 overflow  output  1  sticky: a frame result was discarded.
REQ-013 empty_frame  output  1  one-cycle pulse: a frame closed with zero peaks.

Function
REQ-014 SHALL keep a collect array of K entries sorted by value field (unsigned), descending, plus count 0..K.
REQ-015 On p_valid, the word SHALL be inserted in one cycle via parallel compare-and-shift; no input backpressure, every beat accepted.
REQ-016 Ties: new word SHALL rank below existing entries of equal value (arrival order preserved).
REQ-017 Array full and new value <= smallest entry: word SHALL be dropped; otherwise smallest entry is evicted.
REQ-018 Side and index bits SHALL NOT affect ordering.
REQ-019 A beat with p_valid and p_last together SHALL be included in the closing frame.
REQ-020 Frame close with count>0 and drain FSM in IDLE: collect array and count SHALL copy into output bank at that edge; collect array clears; FSM -> DRAIN.
REQ-021 Latency: m_tvalid SHALL assert the cycle after the p_last cycle.
REQ-022 DRAIN: m_tdata = bank[rd], rd from 0 (largest); rd increments on m_tvalid && m_tready; m_tlast = (rd == bank_count-1).
REQ-023 m_tdata/m_tlast SHALL remain stable while m_tvalid && !m_tready.
REQ-024 Handshake on the m_tlast beat SHALL return FSM to IDLE and deassert m_tvalid next cycle unless a new bank is loaded at the same edge.
REQ-025 Frame close in the same cycle as the m_tlast handshake SHALL be accepted (bank reloaded, m_tvalid stays high, no overflow).
REQ-026 Frame close while DRAIN otherwise busy: result SHALL be discarded, collect array cleared, overflow set.
REQ-027 Frame close with count=0: empty_frame SHALL pulse the next cycle, nothing output, FSM unchanged.
REQ-028 Collection of the next frame SHALL proceed the cycle after p_last, concurrently with draining.

Reset
REQ-029 aresetn low SHALL immediately force: m_tvalid=0, m_tlast=0, m_tdata=0, overflow=0, empty_frame=0, counts=0, rd=0, FSM=IDLE.
REQ-030 Reset mid-drain or mid-frame SHALL abandon all data; first frame after release starts empty.
REQ-031 Release SHALL be synchronised internally so no logic acts on a partial first edge.

Configuration
REQ-032 Macro PEAK_TOPK_STATS_EN defined: outputs peaks_seen[15:0] (accepted p_valid beats) and peaks_dropped[15:0] (REQ-017 drops/evictions plus peaks in REQ-026 discarded frames), both saturating at 16'hFFFF, cleared by reset only.
REQ-033 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification (K=4, VALUE_WIDTH=16)
REQ-034 Values 4,28,A34,514,C3,37 then p_last, m_tready=1 -> beats A34,514,C3,37, m_tlast on 37, m_tvalid first high cycle after p_last.
REQ-035 Values C3(idx1),C3(idx2),C1 + last -> C3 idx1, C3 idx2, C1; tlast on 3rd beat.
REQ-036 m_tready low during drain, second frame closes before m_tlast -> overflow=1, first frame output intact, second lost.
REQ-037 p_last with no peaks -> empty_frame one-cycle pulse, m_tvalid stays 0.
REQ-038 Second frame closes same cycle as first frame's m_tlast handshake -> m_tvalid stays high, second frame follows back-to-back, overflow=0.
REQ-039 aresetn low mid-drain -> m_tvalid=0 asynchronously; after release a 1-peak frame (2837) yields single beat with m_tlast=1.
